// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bus between the instruction-fetch stage and the rest of the core.
//   master : the fetch stage. It drives pcout, the IF/ID register outputs and halted.
//   slave  : memory and pipeline control. It drives instruction, stall, flush and redirect.
interface fetch_stage_if;
    logic [15:0] pcout;
    logic [15:0] instruction;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus2;
    logic        if_valid;
    logic        halted;

    modport master (
        output pcout, if_instr, if_pc, if_pc_plus2, if_valid, halted,
        input  instruction, stall, flush, redirect, redirect_pc
    );

    modport slave (
        input  pcout, if_instr, if_pc, if_pc_plus2, if_valid, halted,
        output instruction, stall, flush, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: owns the program counter and the IF/ID pipeline register.
// It handles stall, flush, branch/jump redirect and a halt instruction.
//   clk   : single clock; all state changes happen on the rising edge
//   reset : asynchronous, active-high
//   bus   : fetch_stage_if.master
//           pcout is the PC register itself. The IF/ID outputs go to decode.
//
// state   | meaning
// --------+----------------------------------------------------------
// FETCH   | PC advances by 2 each unstalled edge; IF/ID captures memory data
// HALTED  | HALT_INSTR was fetched; PC parked; bubbles until reset/redirect
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] HALT_INSTR = 16'hFFFF,
    parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);
    typedef enum logic {FETCH, HALTED} state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] pc_plus2;

    assign pc_plus2  = pc + 16'd2;
    assign bus.pcout = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= FETCH;
            pc              <= RESET_PC;
            bus.if_instr    <= NOP_INSTR;
            bus.if_pc       <= 16'h0000;
            bus.if_pc_plus2 <= 16'h0000;
            bus.if_valid    <= 1'b0;
            bus.halted      <= 1'b0;
        end else if (bus.redirect) begin
            // Redirect wins over stall. The IF/ID pc fields keep their old
            // values behind the bubble.
            state        <= FETCH;
            bus.halted   <= 1'b0;
            pc           <= {bus.redirect_pc[15:1], 1'b0};
            bus.if_instr <= NOP_INSTR;
            bus.if_valid <= 1'b0;
        end else if (bus.flush) begin
            bus.if_instr <= NOP_INSTR;
            bus.if_valid <= 1'b0;
            if (state == FETCH && !bus.stall) begin
                pc <= pc_plus2;
            end
        end else if (!bus.stall) begin
            if (state == FETCH) begin
                bus.if_instr    <= bus.instruction;
                bus.if_pc       <= pc;
                bus.if_pc_plus2 <= pc_plus2;
                bus.if_valid    <= 1'b1;
                if (bus.instruction == HALT_INSTR) begin
                    // The halt word is delivered valid. The PC stays parked on it.
                    state      <= HALTED;
                    bus.halted <= 1'b1;
                end else begin
                    pc <= pc_plus2;
                end
            end else begin
                bus.if_instr <= NOP_INSTR;
                bus.if_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    fetch_stage_if bus();

    fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] mem [0:32767];

    assign bus.instruction = mem[bus.pcout[15:1]];

    // Snapshot order: pcout, if_pc, if_pc_plus2, if_instr, if_valid, halted
    logic [65:0] obs;
    assign obs = {bus.pcout, bus.if_pc, bus.if_pc_plus2, bus.if_instr,
                  bus.if_valid, bus.halted};

    function automatic logic [65:0] ev(input logic [15:0] pco, input logic [15:0] ipc,
                                       input logic [15:0] ipp2, input logic [15:0] ins,
                                       input logic vld, input logic hlt);
        return {pco, ipc, ipp2, ins, vld, hlt};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [65:0] e;
        reset = 1'b1;
        #2;
        e = ev(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL reset_async: got %h want %h", obs, e); end
        step();
        step();
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL reset_held: got %h want %h", obs, e); end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [65:0] e;
        step();
        e = ev(16'h0002, 16'h0000, 16'h0002, 16'h1111, 1'b1, 1'b0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL seq0: got %h want %h", obs, e); end
        step();
        e = ev(16'h0004, 16'h0002, 16'h0004, 16'h2222, 1'b1, 1'b0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL seq1: got %h want %h", obs, e); end
    endtask

    task automatic test_stall();
        logic [65:0] e;
        bus.stall = 1'b1;
        e = ev(16'h0004, 16'h0002, 16'h0004, 16'h2222, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL stall_hold%0d: got %h want %h", i, obs, e); end
        end
        bus.stall = 1'b0;
        step();
        e = ev(16'h0006, 16'h0004, 16'h0006, 16'h3333, 1'b1, 1'b0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL stall_resume: got %h want %h", obs, e); end
    endtask

    task automatic test_halt();
        logic [65:0] e;
        step();
        e = ev(16'h0006, 16'h0006, 16'h0008, 16'hFFFF, 1'b1, 1'b1);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL halt_capture: got %h want %h", obs, e); end
        bus.stall = 1'b1;
        step();
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL halt_stalled: got %h want %h", obs, e); end
        bus.stall = 1'b0;
        step();
        e = ev(16'h0006, 16'h0006, 16'h0008, 16'h0000, 1'b0, 1'b1);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL halt_bubble: got %h want %h", obs, e); end
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL halt_flush: got %h want %h", obs, e); end
        step();
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL halt_parked: got %h want %h", obs, e); end
    endtask

    task automatic test_redirect();
        logic [65:0] e;
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'h0010;
        bus.stall = 1'b1;
        step();
        bus.redirect = 1'b0;
        bus.stall = 1'b0;
        e = ev(16'h0010, 16'h0006, 16'h0008, 16'h0000, 1'b0, 1'b0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL redir_unhalt: got %h want %h", obs, e); end
        step();
        e = ev(16'h0012, 16'h0010, 16'h0012, 16'hABCD, 1'b1, 1'b0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL redir_target: got %h want %h", obs, e); end
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'h0041;
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        step();
        bus.redirect = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        e = ev(16'h0040, 16'h0010, 16'h0012, 16'h0000, 1'b0, 1'b0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL redir_odd_stall: got %h want %h", obs, e); end
        step();
        e = ev(16'h0042, 16'h0040, 16'h0042, 16'h5A5A, 1'b1, 1'b0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL redir_odd_target: got %h want %h", obs, e); end
    endtask

    task automatic test_flush();
        logic [65:0] e;
        bus.flush = 1'b1;
        step();
        e = ev(16'h0044, 16'h0040, 16'h0042, 16'h0000, 1'b0, 1'b0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL flush_adv: got %h want %h", obs, e); end
        bus.stall = 1'b1;
        step();
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL flush_stall: got %h want %h", obs, e); end
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        step();
        e = ev(16'h0046, 16'h0044, 16'h0046, 16'h7777, 1'b1, 1'b0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL flush_resume: got %h want %h", obs, e); end
    endtask

    task automatic test_wrap();
        logic [65:0] e;
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'hFFFF;
        step();
        bus.redirect = 1'b0;
        step();
        e = ev(16'h0000, 16'hFFFE, 16'h0000, 16'h1234, 1'b1, 1'b0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL wrap: got %h want %h", obs, e); end
    endtask

    task automatic test_reset_mid_halt();
        logic [65:0] e;
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'h0006;
        step();
        bus.redirect = 1'b0;
        step();
        e = ev(16'h0006, 16'h0006, 16'h0008, 16'hFFFF, 1'b1, 1'b1);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL pre_reset_halt: got %h want %h", obs, e); end
        bus.stall = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        e = ev(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL reset_mid_halt: got %h want %h", obs, e); end
        step();
        reset = 1'b0;
        bus.stall = 1'b0;
        step();
        e = ev(16'h0002, 16'h0000, 16'h0002, 16'h1111, 1'b1, 1'b0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL post_reset_fetch: got %h want %h", obs, e); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        mem[0]      = 16'h1111;
        mem[1]      = 16'h2222;
        mem[2]      = 16'h3333;
        mem[3]      = 16'hFFFF;
        mem[8]      = 16'hABCD;
        mem[16'h20] = 16'h5A5A;
        mem[16'h21] = 16'h6666;
        mem[16'h22] = 16'h7777;
        mem[16'h7FFF] = 16'h1234;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 16'h0000;

        test_reset();
        test_sequential();
        test_stall();
        test_halt();
        test_redirect();
        test_flush();
        test_wrap();
        test_reset_mid_halt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
